rotate_arbiter: RTL and testbench

//  Shares one 16-bit combinational right-rotator (BarrelShifter: out[i] = in[(i+offset) mod 16])

---
 rtl/rotate_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rotate_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_arbiter.sv
// rotate_arbiter
//   Round-robin arbiter that shares one external 16-bit combinational right
//   rotator (out[i] = in[(i+offset) mod 16]) among N_REQ requesters. The
//   winner's word and rotate amount are driven to the rotator, and the
//   returned result is captured with the winner's ID. The output stage is a
//   single-entry register that can be drained and reloaded in the same cycle.
//
// Ports
//   clk        in   1         clock, rising edge
//   rst        in   1         synchronous active-high reset
//   req_valid  in   N_REQ     per-requester request valid
//   req_ready  out  N_REQ     per-requester accept strobe (one-hot or zero)
//   req_data   in   16*N_REQ  word of requester k in [16k+15:16k]
//   req_amt    in   4*N_REQ   rotate amount of requester k in [4k+3:4k]
//   req_dir    in   N_REQ     0 = rotate right, 1 = rotate left
//   sh_in      out  16        rotator data input
//   sh_offset  out  4         rotator right-rotate offset
//   sh_out     in   16        rotator result
//   rsp_valid  out  1         result register holds valid data
//   rsp_ready  in   1         downstream accepts the result
//   rsp_data   out  16        rotated word
//   rsp_id     out  ID_W      requester that produced rsp_data
//   busy_cnt   out  8         saturating count of pending-but-blocked cycles
module rotate_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [16*N_REQ-1:0]   req_data,
   input  logic [4*N_REQ-1:0]    req_amt,
   input  logic [N_REQ-1:0]      req_dir,
   output logic [15:0]           sh_in,
   output logic [3:0]            sh_offset,
   input  logic [15:0]           sh_out,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [15:0]           rsp_data,
   output logic [ID_W-1:0]       rsp_id,
   output logic [7:0]            busy_cnt
);

   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE_HOT = N_REQ'(1);

   // A left rotate by amt equals a right rotate by -amt (4-bit wrap).
   function automatic logic [3:0] rot_offset(input logic [3:0] amt, input logic dir);
      return dir ? (4'd0 - amt) : amt;
   endfunction

   logic            rsp_valid_q, rsp_valid_d;
   logic [15:0]     rsp_data_q,  rsp_data_d;
   logic [ID_W-1:0] rsp_id_q,    rsp_id_d;
   logic [ID_W-1:0] rr_ptr_q,    rr_ptr_d;
   logic [7:0]      busy_q,      busy_d;

   logic            can_accept;
   logic            found_hi, found_lo;
   logic [ID_W-1:0] idx_hi, idx_lo;
   logic [15:0]     data_hi, data_lo;
   logic [3:0]      amt_hi, amt_lo;
   logic            dir_hi, dir_lo;
   logic            grant_vld;
   logic [ID_W-1:0] win_idx;
   logic [15:0]     win_data;
   logic [3:0]      win_amt;
   logic            win_dir;

   assign can_accept = !rsp_valid_q || rsp_ready;

   // Round-robin search split in two passes: lowest valid index at or above
   // rr_ptr wins; otherwise the lowest valid index below rr_ptr (wrap-around).
   // Descending loops let the last (lowest) match overwrite earlier ones.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      idx_hi   = '0;
      idx_lo   = '0;
      data_hi  = 16'd0;
      data_lo  = 16'd0;
      amt_hi   = 4'd0;
      amt_lo   = 4'd0;
      dir_hi   = 1'b0;
      dir_lo   = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_valid[k]) begin
            if (k >= int'(rr_ptr_q)) begin
               found_hi = 1'b1;
               idx_hi   = k[ID_W-1:0];
               data_hi  = req_data[16*k +: 16];
               amt_hi   = req_amt[4*k +: 4];
               dir_hi   = req_dir[k];
            end else begin
               found_lo = 1'b1;
               idx_lo   = k[ID_W-1:0];
               data_lo  = req_data[16*k +: 16];
               amt_lo   = req_amt[4*k +: 4];
               dir_lo   = req_dir[k];
            end
         end
      end
   end

   assign win_idx   = found_hi ? idx_hi  : idx_lo;
   assign win_data  = found_hi ? data_hi : data_lo;
   assign win_amt   = found_hi ? amt_hi  : amt_lo;
   assign win_dir   = found_hi ? dir_hi  : dir_lo;

   // No grant while in reset so nothing is handshaken during reset.
   assign grant_vld = can_accept && !rst && (found_hi || found_lo);

   assign req_ready = grant_vld ? (ONE_HOT << win_idx) : '0;
   assign sh_in     = grant_vld ? win_data : 16'd0;
   assign sh_offset = grant_vld ? rot_offset(win_amt, win_dir) : 4'd0;

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      rr_ptr_d    = rr_ptr_q;
      busy_d      = busy_q;
      if (grant_vld) begin
         // Covers both an empty register and drain-with-reload (no bubble).
         rsp_valid_d = 1'b1;
         rsp_data_d  = sh_out;
         rsp_id_d    = win_idx;
         rr_ptr_d    = (win_idx == LAST_ID) ? '0 : win_idx + ID_W'(1);
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      if ((|req_valid) && !can_accept && (busy_q != 8'hFF)) begin
         busy_d = busy_q + 8'd1;
      end
   end

   // ---- output register stage ----
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 16'd0;
         rsp_id_q    <= '0;
         rr_ptr_q    <= '0;
         busy_q      <= 8'd0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         rr_ptr_q    <= rr_ptr_d;
         busy_q      <= busy_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Directed testbench for rotate_arbiter with a behavioural model of the
// shared rotator on the sh_in/sh_offset/sh_out return path.
module tb_rotate_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_data;
   logic [15:0] req_amt;
   logic [3:0]  req_dir;
   logic [15:0] sh_in;
   logic [3:0]  sh_offset;
   logic [15:0] sh_out;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_id;
   logic [7:0]  busy_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Expected rotated words for the round-robin table (hand-computed)
   localparam logic [15:0] EXP_RR [4] = '{16'h1234, 16'h1800, 16'h0F00, 16'h00F0};

   always #5 clk = ~clk;

   // Shared rotator: out[i] = in[(i+offset) mod 16]
   logic [31:0] rot_dbl;
   assign rot_dbl = {sh_in, sh_in} >> sh_offset;
   assign sh_out  = rot_dbl[15:0];

   rotate_arbiter #(.N_REQ(4), .ID_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_amt   (req_amt),
      .req_dir   (req_dir),
      .sh_in     (sh_in),
      .sh_offset (sh_offset),
      .sh_out    (sh_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy_cnt  (busy_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [15:0] d, input logic [3:0] a, input logic dir);
      req_data[16*k +: 16] = d;
      req_amt[4*k +: 4]    = a;
      req_dir[k]           = dir;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rsp_ready = 1'b1;
      set_req(0, 16'h1111, 4'd1, 1'b0);
      set_req(1, 16'h2222, 4'd2, 1'b0);
      set_req(2, 16'h3333, 4'd3, 1'b1);
      set_req(3, 16'h4444, 4'd4, 1'b1);
      req_valid = 4'b1111;
      tick();
      tick();
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b, expected 0000", req_ready); end
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b, expected 0", rsp_valid); end
      n_vec++; if (rsp_data !== 16'h0000) begin n_err++; $display("FAIL reset_rsp_data: got %h, expected 0000", rsp_data); end
      n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d, expected 0", rsp_id); end
      n_vec++; if (busy_cnt !== 8'd0) begin n_err++; $display("FAIL reset_busy_cnt: got %0d, expected 0", busy_cnt); end
      n_vec++; if (sh_in !== 16'h0000) begin n_err++; $display("FAIL reset_sh_in: got %h, expected 0000", sh_in); end
      req_valid = 4'b0000;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_rotate_dir();
      // Right rotate by 1 from requester 0
      set_req(0, 16'h8001, 4'd1, 1'b0);
      req_valid = 4'b0001;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rot_r_ready: got %b, expected 0001", req_ready); end
      n_vec++; if (sh_in !== 16'h8001) begin n_err++; $display("FAIL rot_r_sh_in: got %h, expected 8001", sh_in); end
      n_vec++; if (sh_offset !== 4'h1) begin n_err++; $display("FAIL rot_r_offset: got %h, expected 1", sh_offset); end
      tick();
      req_valid = 4'b0000;
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rot_r_valid: got %b, expected 1", rsp_valid); end
      n_vec++; if (rsp_data !== 16'hC000) begin n_err++; $display("FAIL rot_r_data: got %h, expected C000", rsp_data); end
      n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL rot_r_id: got %0d, expected 0", rsp_id); end
      // Left rotate by 1 from requester 2
      set_req(2, 16'h8001, 4'd1, 1'b1);
      req_valid = 4'b0100;
      #1;
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rot_l_ready: got %b, expected 0100", req_ready); end
      n_vec++; if (sh_offset !== 4'hF) begin n_err++; $display("FAIL rot_l_offset: got %h, expected F", sh_offset); end
      tick();
      req_valid = 4'b0000;
      n_vec++; if (rsp_data !== 16'h0003) begin n_err++; $display("FAIL rot_l_data: got %h, expected 0003", rsp_data); end
      n_vec++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL rot_l_id: got %0d, expected 2", rsp_id); end
      // Left rotate by 0 passes the word unchanged
      set_req(2, 16'hA5C3, 4'd0, 1'b1);
      req_valid = 4'b0100;
      #1;
      n_vec++; if (sh_offset !== 4'h0) begin n_err++; $display("FAIL rot_0_offset: got %h, expected 0", sh_offset); end
      tick();
      req_valid = 4'b0000;
      #1;
      n_vec++; if (rsp_data !== 16'hA5C3) begin n_err++; $display("FAIL rot_0_data: got %h, expected A5C3", rsp_data); end
      n_vec++; if (sh_in !== 16'h0000) begin n_err++; $display("FAIL idle_sh_in: got %h, expected 0000", sh_in); end
      // Drain with no grant: valid drops, data holds
      tick();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b, expected 0", rsp_valid); end
      n_vec++; if (rsp_data !== 16'hA5C3) begin n_err++; $display("FAIL drain_data_hold: got %h, expected A5C3", rsp_data); end
      n_vec++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL drain_id_hold: got %0d, expected 2", rsp_id); end
   endtask

   task automatic test_round_robin();
      logic [3:0] oh;
      int         pk;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(0, 16'h1234, 4'd0, 1'b0);
      set_req(1, 16'h8001, 4'd4, 1'b0);
      set_req(2, 16'h00F0, 4'd4, 1'b1);
      set_req(3, 16'hF000, 4'd8, 1'b0);
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         oh = 4'b0001 << (i % 4);
         n_vec++; if (req_ready !== oh) begin n_err++; $display("FAIL rr_grant_%0d: got %b, expected %b", i, req_ready, oh); end
         if (i > 0) begin
            pk = (i - 1) % 4;
            n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid_%0d: got %b, expected 1", i, rsp_valid); end
            n_vec++; if (rsp_id !== 2'(pk)) begin n_err++; $display("FAIL rr_id_%0d: got %0d, expected %0d", i, rsp_id, pk); end
            n_vec++; if (rsp_data !== EXP_RR[pk]) begin n_err++; $display("FAIL rr_data_%0d: got %h, expected %h", i, rsp_data, EXP_RR[pk]); end
         end
         tick();
      end
      n_vec++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL rr_last_id: got %0d, expected 1", rsp_id); end
      n_vec++; if (rsp_data !== 16'h1800) begin n_err++; $display("FAIL rr_last_data: got %h, expected 1800", rsp_data); end
   endtask

   task automatic test_stall();
      set_req(1, 16'h0F0F, 4'd4, 1'b0);
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_ready_0: got %b, expected 0000", req_ready); end
      for (int j = 0; j < 5; j++) begin
         tick();
         n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_ready_%0d: got %b, expected 0000", j + 1, req_ready); end
         n_vec++; if (rsp_data !== 16'h1800 || rsp_id !== 2'd1 || rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_hold_%0d: got v=%b d=%h id=%0d, expected v=1 d=1800 id=1", j, rsp_valid, rsp_data, rsp_id);
         end
      end
      n_vec++; if (busy_cnt !== 8'd5) begin n_err++; $display("FAIL stall_busy: got %0d, expected 5", busy_cnt); end
      rsp_ready = 1'b1;
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL release_ready: got %b, expected 0010", req_ready); end
      tick();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hF0F0 || rsp_id !== 2'd1) begin
         n_err++; $display("FAIL release_rsp: got v=%b d=%h id=%0d, expected v=1 d=F0F0 id=1", rsp_valid, rsp_data, rsp_id);
      end
      n_vec++; if (busy_cnt !== 8'd5) begin n_err++; $display("FAIL release_busy: got %0d, expected 5", busy_cnt); end
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      set_req(0, 16'h0001, 4'd15, 1'b0);
      req_valid = 4'b1101;
      tick();
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b, expected 1", rsp_valid); end
      rst = 1'b1;
      tick();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_valid: got %b, expected 0", rsp_valid); end
      n_vec++; if (busy_cnt !== 8'd0) begin n_err++; $display("FAIL mid_busy: got %0d, expected 0", busy_cnt); end
      n_vec++; if (rsp_data !== 16'h0000) begin n_err++; $display("FAIL mid_rsp_data: got %h, expected 0000", rsp_data); end
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_ready_in_rst: got %b, expected 0000", req_ready); end
      rst = 1'b0;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_first_grant: got %b, expected 0001", req_ready); end
      tick();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'h0002) begin
         n_err++; $display("FAIL mid_first_rsp: got v=%b d=%h id=%0d, expected v=1 d=0002 id=0", rsp_valid, rsp_data, rsp_id);
      end
   endtask

   task automatic test_saturate();
      rsp_ready = 1'b0;
      req_valid = 4'b1101;
      repeat (254) tick();
      n_vec++; if (busy_cnt !== 8'd254) begin n_err++; $display("FAIL sat_254: got %0d, expected 254", busy_cnt); end
      tick();
      n_vec++; if (busy_cnt !== 8'd255) begin n_err++; $display("FAIL sat_255: got %0d, expected 255", busy_cnt); end
      repeat (45) tick();
      n_vec++; if (busy_cnt !== 8'd255) begin n_err++; $display("FAIL sat_hold: got %0d, expected 255", busy_cnt); end
      n_vec++; if (rsp_data !== 16'h0002 || req_ready !== 4'b0000) begin
         n_err++; $display("FAIL sat_stall_hold: got d=%h ready=%b, expected d=0002 ready=0000", rsp_data, req_ready);
      end
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      tick();
      tick();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL sat_drain_valid: got %b, expected 0", rsp_valid); end
      n_vec++; if (busy_cnt !== 8'd255) begin n_err++; $display("FAIL sat_no_clear: got %0d, expected 255", busy_cnt); end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 4'b0000;
      req_data  = 64'd0;
      req_amt   = 16'd0;
      req_dir   = 4'b0000;
      rsp_ready = 1'b0;
      test_reset();
      test_rotate_dir();
      test_round_robin();
      test_stall();
      test_reset_mid();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
